// File: rtl/a2d_pkg.sv
// ============================================================================
//  Module   : a2d_pkg
//  Purpose  : Shared types, constants and command builder for the A2D SPI front end.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package a2d_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FRM1 = 2'd1,
        GAP  = 2'd2,
        FRM2 = 2'd3
    } a2d_state_e;

    function automatic logic [FRAME_BITS-1:0] a2d_cmd(input logic [2:0] chnnl);
        return {2'b00, chnnl, 11'h000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mstr16.sv
// ============================================================================
//  Module   : spi_mstr16
//  Purpose  : One 16-bit SPI mode-3 frame: SS_n porches, SCLK divider, tx/rx shifting.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrt,
    input  logic [FRAME_BITS-1:0] cmd,
    input  logic                  MISO,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rd_data
);

    localparam int HALF   = SCLK_DIV / 2;
    localparam int LAST   = 17 * SCLK_DIV - 1;
    localparam int CW     = $clog2(17 * SCLK_DIV);
    localparam int LOG2D  = $clog2(SCLK_DIV);

    logic                  active_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [FRAME_BITS-2:0] tx_q;
    logic [FRAME_BITS-1:0] rx_q;
    logic                  ss_n_q;
    logic                  sclk_q;
    logic                  sclk_d;
    logic                  mosi_q;

    // SCLK is low in the second half of each D-long slot, for the 16 data periods only
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        sclk_d = ~(cnt_d[LOG2D-1] && (cnt_d < CW'(16 * SCLK_DIV)));
        done   = active_q && (cnt_q == CW'(LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            ss_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else if (!active_q) begin
            if (wrt) begin
                active_q <= 1'b1;
                cnt_q    <= '0;
                ss_n_q   <= 1'b0;
                sclk_q   <= 1'b1;
                tx_q     <= cmd[FRAME_BITS-2:0];
                mosi_q   <= cmd[FRAME_BITS-1];
            end
        end else if (done) begin
            active_q <= 1'b0;
            ss_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
            // The first SCLK fall keeps bit 15, already driven when SS_n fell
            if (sclk_q && !sclk_d && (cnt_d != CW'(HALF))) begin
                tx_q   <= {tx_q[FRAME_BITS-3:0], 1'b0};
                mosi_q <= tx_q[FRAME_BITS-2];
            end
            if (!sclk_q && sclk_d) begin
                rx_q <= {rx_q[FRAME_BITS-2:0], MISO};
            end
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign rd_data = rx_q;

endmodule

`default_nettype wire

// File: rtl/a2d_spi_ctrl.sv
// ============================================================================
//  Module   : a2d_spi_ctrl
//  Purpose  : Two-frame SPI conversion sequencer for the 8-channel 12-bit slider ADC.
//             Optional macro A2D_RES_INVERT_EN returns the bitwise-inverted result.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module a2d_spi_ctrl
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        a2d_SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    localparam int GW = $clog2(SCLK_DIV);

    a2d_state_e            state_q, state_d;
    logic [2:0]            chnnl_q, chnnl_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  wrt_q, wrt_d;
    logic                  cmplt_q, cmplt_d;
    logic [11:0]           res_q, res_d;

    logic                  spi_done;
    logic [FRAME_BITS-1:0] spi_rd;
    logic [11:0]           rx_res;
    logic                  rx_hi_unused;

    assign rx_hi_unused = ^spi_rd[FRAME_BITS-1:12];

`ifdef A2D_RES_INVERT_EN
    assign rx_res = ~spi_rd[11:0];
`else
    assign rx_res = spi_rd[11:0];
`endif

    spi_mstr16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_q),
        .cmd     (a2d_cmd(chnnl_q)),
        .MISO    (MISO),
        .SS_n    (a2d_SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (spi_done),
        .rd_data (spi_rd)
    );

    // wrt is registered, so each frame is kicked one cycle ahead of its SS_n fall
    always_comb begin
        state_d = state_q;
        chnnl_d = chnnl_q;
        gap_d   = '0;
        wrt_d   = 1'b0;
        cmplt_d = cmplt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    state_d = FRM1;
                    chnnl_d = chnnl;
                    cmplt_d = 1'b0;
                    wrt_d   = 1'b1;
                end
            end
            FRM1: begin
                if (spi_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(SCLK_DIV - 2)) begin
                    wrt_d = 1'b1;
                end
                if (gap_q == GW'(SCLK_DIV - 1)) begin
                    state_d = FRM2;
                    gap_d   = '0;
                end
            end
            FRM2: begin
                if (spi_done) begin
                    state_d = IDLE;
                    cmplt_d = 1'b1;
                    res_d   = rx_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chnnl_q <= '0;
            gap_q   <= '0;
            wrt_q   <= 1'b0;
            cmplt_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            chnnl_q <= chnnl_d;
            gap_q   <= gap_d;
            wrt_q   <= wrt_d;
            cmplt_q <= cmplt_d;
            res_q   <= res_d;
        end
    end

    assign cnv_cmplt = cmplt_q;
    assign res       = res_q;

endmodule

`default_nettype wire

// File: tb/tb_a2d_spi_ctrl.sv
// ============================================================================
//  Module   : tb_a2d_spi_ctrl
//  Purpose  : Self-checking bench for a2d_spi_ctrl with a mode-3 ADC model and scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_a2d_spi_ctrl;

    localparam int D   = 32;
    localparam int LAT = 35 * D + 1;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl    = 3'd0;
    logic        MISO     = 1'b1;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;

    a2d_spi_ctrl #(
        .SCLK_DIV (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .MISO      (MISO),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (a2d_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks   = 0;
    int          errors   = 0;
    int          ss_falls = 0;
    int          t0       = 0;
    logic [11:0] adc_val [8];
    logic [2:0]  prev_ch  = 3'd0;
    logic [11:0] exp_res_q [$];
    logic [15:0] exp_cmd_q [$];

    function automatic logic [11:0] exp_of(input logic [11:0] v);
`ifdef A2D_RES_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] cmd_of(input logic [2:0] c);
        return {2'b00, c, 11'h000};
    endfunction

    // ADC: replies with the channel addressed in the previous frame, junk in bits 15:12
    task automatic adc_model();
        logic        ps = 1'b1;
        logic        pk = 1'b1;
        logic [15:0] sh = '0;
        logic [15:0] mw = '0;
        logic [15:0] e;
        int          nf = 0;
        int          nb = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ps && !a2d_SS_n) begin
                sh = {4'hC, adc_val[prev_ch]};
                MISO = sh[15];
                nf = 0;
                nb = 0;
                ss_falls++;
            end else if (!a2d_SS_n) begin
                if (pk && !SCLK) begin
                    nf++;
                    if (nf > 1) begin
                        sh = {sh[14:0], 1'b0};
                        MISO = sh[15];
                    end
                end
                if (!pk && SCLK) begin
                    mw = {mw[14:0], MOSI};
                    nb++;
                end
            end
            if (!ps && a2d_SS_n && nb == 16) begin
                prev_ch = mw[13:11];
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL mosi_word: unexpected frame, got %h", mw);
                end else begin
                    e = exp_cmd_q.pop_front();
                    if (mw !== e) begin
                        errors++;
                        $display("FAIL mosi_word: got %h expected %h", mw, e);
                    end
                end
            end
            ps = a2d_SS_n;
            pk = SCLK;
        end
    endtask

    task automatic cmplt_monitor();
        logic        pc = 1'b0;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1 && pc !== 1'b1) begin
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL res_scoreboard: unexpected completion, res=%h", res);
                end else begin
                    e = exp_res_q.pop_front();
                    if (res !== e) begin
                        errors++;
                        $display("FAIL res_scoreboard: got %h expected %h", res, e);
                    end
                end
            end
            pc = cnv_cmplt;
        end
    endtask

    task automatic start(input logic [2:0] ch);
        @(negedge clk);
        chnnl    = ch;
        strt_cnv = 1'b1;
        exp_res_q.push_back(exp_of(adc_val[ch]));
        exp_cmd_q.push_back(cmd_of(ch));
        exp_cmd_q.push_back(cmd_of(ch));
        @(negedge clk);
        strt_cnv = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (cnv_cmplt !== 1'b1 && n < LAT + 200) begin
            @(negedge clk);
            n++;
        end
        if (cnv_cmplt !== 1'b1) begin
            checks++;
            errors++;
            lat = -1;
            $display("FAIL wait_done: timeout, cnv_cmplt=%b required 1", cnv_cmplt);
        end else begin
            lat = cyc - t0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        checks += 5;
        if (a2d_SS_n !== 1'b1)  begin errors++; $display("FAIL rst_ss_n: got %b expected 1", a2d_SS_n); end
        if (SCLK !== 1'b1)      begin errors++; $display("FAIL rst_sclk: got %b expected 1", SCLK); end
        if (MOSI !== 1'b0)      begin errors++; $display("FAIL rst_mosi: got %b expected 0", MOSI); end
        if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL rst_cmplt: got %b expected 0", cnv_cmplt); end
        if (res !== 12'h000)    begin errors++; $display("FAIL rst_res: got %h expected 000", res); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (a2d_SS_n !== 1'b1) begin errors++; $display("FAIL idle_ss_n: got %b expected 1", a2d_SS_n); end
    endtask

    task automatic test_channel();
        int lat;
        int f0 = ss_falls;
        adc_val[3] = 12'hA5C;
        start(3'd3);
        checks++;
        if (a2d_SS_n !== 1'b1) begin errors++; $display("FAIL ss_cycle0: got %b expected 1", a2d_SS_n); end
        @(negedge clk);
        checks++;
        if (a2d_SS_n !== 1'b0) begin errors++; $display("FAIL ss_cycle1: got %b expected 0", a2d_SS_n); end
        wait_done(lat);
        checks += 4;
        if (lat != LAT)           begin errors++; $display("FAIL ch3_latency: got %0d expected %0d", lat, LAT); end
        if (res !== 12'hA5C)      begin errors++; $display("FAIL ch3_res: got %h expected a5c", exp_of(res)); end
        if (a2d_SS_n !== 1'b1)    begin errors++; $display("FAIL ch3_ss_end: got %b expected 1", a2d_SS_n); end
        if (ss_falls - f0 != 2)   begin errors++; $display("FAIL ch3_frames: got %0d expected 2", ss_falls - f0); end
    endtask

    task automatic test_sweep();
        logic [2:0]  chs  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        logic [11:0] vals [6] = '{12'h000, 12'hFFF, 12'h800, 12'h001, 12'h7FE, 12'h123};
        int lat;
        int f0;
        for (int i = 0; i < 6; i++) begin
            adc_val[chs[i]] = vals[i];
            f0 = ss_falls;
            start(chs[i]);
            wait_done(lat);
            checks++;
            if (ss_falls - f0 != 2) begin
                errors++;
                $display("FAIL sweep_frames ch%0d: got %0d expected 2", chs[i], ss_falls - f0);
            end
        end
    endtask

    task automatic test_busy_start();
        int lat;
        int f0 = ss_falls;
        int f1;
        adc_val[5] = 12'h555;
        adc_val[6] = 12'h666;
        start(3'd2);
        repeat (100) @(negedge clk);
        chnnl = 3'd5; strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        while (cyc - t0 < 560) @(negedge clk);
        chnnl = 3'd6; strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        wait_done(lat);
        checks += 2;
        if (lat != LAT)         begin errors++; $display("FAIL busy_latency: got %0d expected %0d", lat, LAT); end
        if (ss_falls - f0 != 2) begin errors++; $display("FAIL busy_frames: got %0d expected 2", ss_falls - f0); end
        f1 = ss_falls;
        repeat (200) @(negedge clk);
        checks += 2;
        if (ss_falls != f1)     begin errors++; $display("FAIL busy_no_restart: got %0d falls expected 0", ss_falls - f1); end
        if (cnv_cmplt !== 1'b1) begin errors++; $display("FAIL busy_sticky: got %b expected 1", cnv_cmplt); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int prev = 0;
        int now;
        @(negedge clk);
        chnnl    = 3'd4;
        strt_cnv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_res_q.push_back(exp_of(adc_val[4]));
            exp_cmd_q.push_back(cmd_of(3'd4));
            exp_cmd_q.push_back(cmd_of(3'd4));
        end
        @(negedge clk);
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_done(lat);
            now = cyc;
            if (k == 2) strt_cnv = 1'b0;
            checks++;
            if (k == 0 && lat != LAT) begin
                errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT);
            end
            if (k > 0 && now - prev != LAT + 1) begin
                errors++; $display("FAIL b2b_period: got %0d expected %0d", now - prev, LAT + 1);
            end
            prev = now;
            if (k < 2) begin
                @(negedge clk);
                checks++;
                if (cnv_cmplt !== 1'b0) begin
                    errors++; $display("FAIL b2b_pulse_width: cnv_cmplt=%b expected 0", cnv_cmplt);
                end
            end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        int f0;
        start(3'd7);
        while (cyc - t0 < 600) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (a2d_SS_n !== 1'b1)  begin errors++; $display("FAIL midrst_ss_n: got %b expected 1", a2d_SS_n); end
        if (SCLK !== 1'b1)      begin errors++; $display("FAIL midrst_sclk: got %b expected 1", SCLK); end
        if (res !== 12'h000)    begin errors++; $display("FAIL midrst_res: got %h expected 000", res); end
        if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL midrst_cmplt: got %b expected 0", cnv_cmplt); end
        exp_res_q.delete();
        exp_cmd_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        f0 = ss_falls;
        start(3'd1);
        wait_done(lat);
        checks += 2;
        if (lat != LAT)         begin errors++; $display("FAIL postrst_latency: got %0d expected %0d", lat, LAT); end
        if (ss_falls - f0 != 2) begin errors++; $display("FAIL postrst_frames: got %0d expected 2", ss_falls - f0); end
    endtask

    task automatic test_invert();
        int lat;
        logic [11:0] e;
`ifdef A2D_RES_INVERT_EN
        e = 12'hF0F;
`else
        e = 12'h0F0;
`endif
        adc_val[5] = 12'h0F0;
        start(3'd5);
        wait_done(lat);
        checks++;
        if (res !== e) begin errors++; $display("FAIL invert_res: got %h expected %h", res, e); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h3C3;
        fork
            adc_model();
            cmplt_monitor();
        join_none
        test_reset();
        test_channel();
        test_sweep();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_invert();
        repeat (5) @(negedge clk);
        checks += 2;
        if (exp_res_q.size() != 0) begin errors++; $display("FAIL res_queue_drain: %0d left expected 0", exp_res_q.size()); end
        if (exp_cmd_q.size() != 0) begin errors++; $display("FAIL cmd_queue_drain: %0d left expected 0", exp_cmd_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
